// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a single-entry
// fetch buffer toward decode, and redirect/misalignment handling.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    output logic [31:0] pc_plus4,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    output logic        misalign_err
);
    localparam logic [2:0] S_ISSUE = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic        aligned;
    logic        req_fire;

    assign pc_plus4       = pc + 32'd4;
    assign aligned        = (pc[1:0] == 2'b00);
    // Gated by rst_n so no request escapes while reset is held low.
    assign imem_req_valid = rst_n && (state == S_ISSUE) && aligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign misalign_err   = (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ISSUE;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0;
            if_instr    <= 32'h0;
            if_pc_plus4 <= 32'h0;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (!aligned) begin
                        if (redirect) pc    <= pc_next;
                        else          state <= S_ERR;
                    end else begin
                        if (redirect) pc <= pc_next;
                        // An accepted request under redirect still owes a response.
                        if (req_fire) state <= redirect ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc    <= pc_next;
                        state <= imem_rsp_valid ? S_ISSUE : S_DRAIN;
                    end else if (imem_rsp_valid) begin
                        if_pc       <= pc;
                        if_instr    <= imem_rsp_data;
                        if_pc_plus4 <= pc_plus4;
                        if_valid    <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect || id_ready) begin
                        pc       <= pc_next;
                        if_valid <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (redirect)       pc    <= pc_next;
                    if (imem_rsp_valid) state <= S_ISSUE;
                end
                S_ERR: begin
                    if (redirect && (pc_next[1:0] == 2'b00)) begin
                        pc    <= pc_next;
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_next;
    logic        redirect = 1'b0;
    logic [31:0] pc_plus4;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, if_pc_plus4;
    logic        id_ready = 1'b0;
    logic        misalign_err;

    logic [31:0] tgt = 32'h0;
    assign pc_next = redirect ? tgt : pc_plus4;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .redirect(redirect),
        .pc_plus4(pc_plus4), .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4), .id_ready(id_ready), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: outstanding request, discard flag, held instruction, error flag.
    logic [31:0] m_pc, m_ipc, m_ins, m_ipc4;
    logic        m_out, m_drop, m_hold, m_err;
    logic [31:0] n_pc, n_ipc, n_ins, n_ipc4;
    logic        n_out, n_drop, n_hold, n_err;
    logic        exp_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_ipc <= 32'h0; m_ins <= 32'h0; m_ipc4 <= 32'h0;
            m_out <= 1'b0; m_drop <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0;
        end else begin
            m_pc <= n_pc; m_ipc <= n_ipc; m_ins <= n_ins; m_ipc4 <= n_ipc4;
            m_out <= n_out; m_drop <= n_drop; m_hold <= n_hold; m_err <= n_err;
        end
    end

    always @(negedge clk) begin
        exp_rv = rst_n && !m_out && !m_hold && !m_err && (m_pc[1:0] == 2'b00);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_hold});
        chk("if_pc", if_pc, m_ipc);
        chk("if_instr", if_instr, m_ins);
        chk("if_pc_plus4", if_pc_plus4, m_ipc4);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        n_pc = m_pc; n_ipc = m_ipc; n_ins = m_ins; n_ipc4 = m_ipc4;
        n_out = m_out; n_drop = m_drop; n_hold = m_hold; n_err = m_err;
        if (m_err) begin
            if (redirect && pc_next[1:0] == 2'b00) begin n_pc = pc_next; n_err = 1'b0; end
        end else if (m_hold) begin
            if (redirect || id_ready) begin n_pc = pc_next; n_hold = 1'b0; end
        end else if (m_out) begin
            if (imem_rsp_valid) begin
                if (!m_drop && !redirect) begin
                    n_ipc = m_pc; n_ins = imem_rsp_data; n_ipc4 = m_pc + 32'd4; n_hold = 1'b1;
                end
                n_out = 1'b0; n_drop = 1'b0;
            end else if (redirect) n_drop = 1'b1;
            if (redirect) n_pc = pc_next;
        end else if (m_pc[1:0] != 2'b00) begin
            if (redirect) n_pc = pc_next; else n_err = 1'b1;
        end else begin
            if (imem_req_ready) begin n_out = 1'b1; n_drop = redirect; end
            if (redirect) n_pc = pc_next;
        end
    end

    // Memory responder and transaction logging, advanced one cycle per tick.
    logic        rsp_en = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] acc_q[$];
    int          hand_q[$];

    task automatic tick();
        logic acc, dlv;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        dlv = imem_rsp_valid;
        if (if_valid && id_ready && !redirect) hand_q.push_back(cyc);
        if (acc) acc_q.push_back(a);
        @(posedge clk); #1;
        if (dlv) pending = 1'b0;
        if (acc) begin pending = 1'b1; pend_addr = a; end
        imem_rsp_valid = pending && rsp_en;
        imem_rsp_data  = {~pend_addr[15:0], pend_addr[15:0]};
    endtask

    task automatic wait_acc(input string nm);
        int n0 = acc_q.size();
        for (int i = 0; i < 40 && acc_q.size() == n0; i++) tick();
        chk({nm, "_acc_timeout"}, {31'b0, acc_q.size() > n0}, 32'd1);
    endtask

    task automatic wait_ifv(input string nm);
        for (int i = 0; i < 40 && !if_valid; i++) tick();
        chk({nm, "_ifv_timeout"}, {31'b0, if_valid}, 32'd1);
    endtask

    task automatic wait_reqv(input string nm);
        for (int i = 0; i < 40 && !imem_req_valid; i++) tick();
        chk({nm, "_reqv_timeout"}, {31'b0, imem_req_valid}, 32'd1);
    endtask

    logic [31:0] sv_pc, sv_ins;
    int          n0;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);
        chk("rst_addr", imem_req_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        imem_req_ready = 1'b1; rsp_en = 1'b1; id_ready = 1'b1; rst_n = 1'b1;

        // Straight-line fetch
        repeat (10) tick();
        chk("line_n_acc", {31'b0, acc_q.size() >= 3}, 32'd1);
        chk("line_n_hand", {31'b0, hand_q.size() >= 3}, 32'd1);
        if (acc_q.size() >= 3) begin
            chk("line_addr0", acc_q[0], 32'h0);
            chk("line_addr1", acc_q[1], 32'h4);
            chk("line_addr2", acc_q[2], 32'h8);
        end
        if (hand_q.size() >= 3) begin
            chk("line_period0", hand_q[1] - hand_q[0], 32'd3);
            chk("line_period1", hand_q[2] - hand_q[1], 32'd3);
        end

        // Decode stall
        id_ready = 1'b0;
        wait_ifv("stall");
        sv_pc = if_pc; sv_ins = if_instr; n0 = acc_q.size();
        repeat (5) tick();
        chk("stall_if_pc", if_pc, sv_pc);
        chk("stall_if_instr", if_instr, sv_ins);
        chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_no_req", acc_q.size(), n0);
        id_ready = 1'b1;
        tick();
        chk("stall_release", {31'b0, if_valid}, 32'd0);

        // Redirect while waiting for a response
        rsp_en = 1'b0; acc_q.delete();
        wait_acc("wait_redir_a");
        redirect = 1'b1; tgt = 32'h100;
        tick();
        redirect = 1'b0; rsp_en = 1'b1; acc_q.delete();
        repeat (2) begin
            tick();
            chk("wait_redir_drop", {31'b0, if_valid}, 32'd0);
        end
        wait_acc("wait_redir_b");
        if (acc_q.size() > 0) chk("wait_redir_addr", acc_q[0], 32'h100);

        // Redirect in HOLD overrides id_ready
        id_ready = 1'b0;
        wait_ifv("hold_redir");
        id_ready = 1'b1; redirect = 1'b1; tgt = 32'h200;
        hand_q.delete(); acc_q.delete();
        tick();
        redirect = 1'b0;
        chk("hold_redir_ifv", {31'b0, if_valid}, 32'd0);
        chk("hold_redir_noconsume", hand_q.size(), 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h200);
        wait_acc("hold_redir");
        if (acc_q.size() > 0) chk("hold_redir_acc", acc_q[0], 32'h200);

        // Misaligned redirect, then recovery
        imem_req_ready = 1'b0;
        wait_reqv("mis");
        redirect = 1'b1; tgt = 32'h102;
        tick();
        redirect = 1'b0;
        chk("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        repeat (2) tick();
        chk("mis_err_hold", {31'b0, misalign_err}, 32'd1);
        chk("mis_err_noreq", {31'b0, imem_req_valid}, 32'd0);
        redirect = 1'b1; tgt = 32'h104;
        tick();
        redirect = 1'b0;
        chk("mis_clear", {31'b0, misalign_err}, 32'd0);
        chk("mis_clear_req", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_clear_addr", imem_req_addr, 32'h104);
        imem_req_ready = 1'b1;

        // PC wraparound
        id_ready = 1'b0;
        wait_ifv("wrap");
        redirect = 1'b1; tgt = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        id_ready = 1'b1; acc_q.delete();
        wait_acc("wrap_a");
        wait_acc("wrap_b");
        if (acc_q.size() > 1) chk("wrap_next_addr", acc_q[1], 32'h0);

        // Reset during WAIT, stale response afterward
        rsp_en = 1'b0; acc_q.delete();
        wait_acc("rst_wait");
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("mrst_if_pc", if_pc, 32'd0);
        chk("mrst_if_instr", if_instr, 32'd0);
        chk("mrst_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("mrst_addr", imem_req_addr, 32'd0);
        imem_req_ready = 1'b0;
        tick();
        rst_n = 1'b1; rsp_en = 1'b1;
        tick();
        tick();
        chk("stale_rsp_ignored", {31'b0, if_valid}, 32'd0);
        imem_req_ready = 1'b1; acc_q.delete();
        wait_acc("post_rst");
        if (acc_q.size() > 0) chk("post_rst_addr", acc_q[0], 32'h0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
